// File: rtl/lut_seq_pkg.sv
// Shared widths, FSM encoding and index helpers for the LUT layer sequencer.
// Layer geometry lives here so the sequencer and the table RAM agree on it.
package lut_seq_pkg;
  localparam int NEURONS = 16;
  localparam int FAN_IN  = 4;
  localparam int IN_BW   = 2;
  localparam int OUT_BW  = 2;
  localparam int ADDR_W  = FAN_IN * IN_BW;
  localparam int NIDX_W  = $clog2(NEURONS);
  localparam int RAM_AW  = NIDX_W + ADDR_W;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    LAST = 2'd2,
    DONE = 2'd3
  } state_t;

  typedef struct packed {
    logic              we;
    logic [NIDX_W-1:0] neuron;
    logic [ADDR_W-1:0] addr;
    logic [OUT_BW-1:0] data;
  } cfg_req_t;

  function automatic logic [ADDR_W-1:0] in_slice(
    input logic [NEURONS*ADDR_W-1:0] v,
    input logic [NIDX_W-1:0]         n
  );
    return v[n*ADDR_W +: ADDR_W];
  endfunction

  // Each neuron owns a contiguous 2^ADDR_W window of the shared table.
  function automatic logic [RAM_AW-1:0] ram_addr(
    input logic [NIDX_W-1:0] n,
    input logic [ADDR_W-1:0] idx
  );
    return {n, idx};
  endfunction
endpackage

// File: rtl/lut_table_ram.sv
// Simple dual-port table store: one write port, one registered read port.
// No reset, so programmed tables survive a sequencer reset.
module lut_table_ram #(
  parameter int AW = 12,
  parameter int DW = 2
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);
  (* ram_style = "distributed", rom_style = "distributed" *)
  logic [DW-1:0] mem [2**AW];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end
endmodule

// File: rtl/lut_layer_sequencer.sv
// Time-multiplexed LogicNets layer: one neuron per cycle through a shared,
// runtime-programmable truth-table RAM, with valid/ready on both sides.
module lut_layer_sequencer
  import lut_seq_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [NEURONS*ADDR_W-1:0] in_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [NEURONS*OUT_BW-1:0] out_data,
  input  logic                      cfg_we,
  input  logic [NIDX_W-1:0]         cfg_neuron,
  input  logic [ADDR_W-1:0]         cfg_addr,
  input  logic [OUT_BW-1:0]         cfg_data,
  output logic                      cfg_ready,
  output logic                      cfg_drop
);
  state_t                           state_q, state_d;
  logic [NIDX_W-1:0]                n_q;
  logic [NIDX_W-1:0]                rd_n_q;
  logic                             rd_pend_q;
  logic [NEURONS*ADDR_W-1:0]        cap_q;
  logic [NEURONS-1:0][OUT_BW-1:0]   out_q;
  logic                             out_valid_q;
  logic                             cfg_drop_q;
  logic [OUT_BW-1:0]                rdata;
  logic [RAM_AW-1:0]                raddr;
  cfg_req_t                         cfg;
  logic                             accept;
  logic                             wr_en;

  assign cfg       = '{we: cfg_we, neuron: cfg_neuron, addr: cfg_addr, data: cfg_data};
  assign in_ready  = (state_q == IDLE);
  assign cfg_ready = (state_q == IDLE);
  assign accept    = in_ready && in_valid;
  assign wr_en     = cfg.we && cfg_ready;
  assign raddr     = ram_addr(n_q, in_slice(cap_q, n_q));
  assign out_valid = out_valid_q;
  assign out_data  = out_q;
  assign cfg_drop  = cfg_drop_q;

  lut_table_ram #(
    .AW (RAM_AW),
    .DW (OUT_BW)
  ) u_ram (
    .clk   (clk),
    .we    (wr_en),
    .waddr (ram_addr(cfg.neuron, cfg.addr)),
    .wdata (cfg.data),
    .raddr (raddr),
    .rdata (rdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (in_valid) state_d = RUN;
      RUN:  if (n_q == NIDX_W'(NEURONS-1)) state_d = LAST;
      LAST: state_d = DONE;
      DONE: if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // rd_n_q tags the read in flight so the returning word lands in its own
  // slice without subtracting from the counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      n_q         <= '0;
      rd_n_q      <= '0;
      rd_pend_q   <= 1'b0;
      cap_q       <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      cfg_drop_q  <= 1'b0;
    end else begin
      cfg_drop_q <= cfg.we && !cfg_ready;
      case (state_q)
        IDLE: if (accept) begin
          cap_q     <= in_data;
          n_q       <= '0;
          rd_pend_q <= 1'b0;
        end
        RUN: begin
          rd_n_q    <= n_q;
          rd_pend_q <= 1'b1;
          if (n_q != NIDX_W'(NEURONS-1)) n_q <= n_q + NIDX_W'(1);
          if (rd_pend_q) out_q[rd_n_q] <= rdata;
        end
        LAST: begin
          out_q[rd_n_q] <= rdata;
          rd_pend_q     <= 1'b0;
          out_valid_q   <= 1'b1;
        end
        DONE: if (out_ready) out_valid_q <= 1'b0;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_lut_layer_sequencer.sv
// Directed bench for lut_layer_sequencer: table programming, latency,
// backpressure, config rejection, same-edge write, and async reset.
module tb_lut_layer_sequencer;
  import lut_seq_pkg::*;

  logic                      clk = 1'b0;
  logic                      rst_n = 1'b0;
  logic                      in_valid = 1'b0;
  logic                      in_ready;
  logic [NEURONS*ADDR_W-1:0] in_data = '0;
  logic                      out_valid;
  logic                      out_ready = 1'b0;
  logic [NEURONS*OUT_BW-1:0] out_data;
  logic                      cfg_we = 1'b0;
  logic [NIDX_W-1:0]         cfg_neuron = '0;
  logic [ADDR_W-1:0]         cfg_addr = '0;
  logic [OUT_BW-1:0]         cfg_data = '0;
  logic                      cfg_ready;
  logic                      cfg_drop;

  int total = 0;
  int bad   = 0;

  lut_layer_sequencer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .cfg_we     (cfg_we),
    .cfg_neuron (cfg_neuron),
    .cfg_addr   (cfg_addr),
    .cfg_data   (cfg_data),
    .cfg_ready  (cfg_ready),
    .cfg_drop   (cfg_drop)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [NEURONS*ADDR_W-1:0] mkvec(input logic [7:0] s2);
    logic [NEURONS*ADDR_W-1:0] v;
    for (int i = 0; i < NEURONS; i++) v[i*ADDR_W +: ADDR_W] = 8'(i*37 + 5);
    v[2*ADDR_W +: ADDR_W] = s2;
    return v;
  endfunction

  function automatic logic [NEURONS*OUT_BW-1:0] expout(input logic [1:0] s2);
    logic [NEURONS*OUT_BW-1:0] e;
    e = '1;
    e[2*OUT_BW +: OUT_BW] = s2;
    return e;
  endfunction

  task automatic start(input logic [NEURONS*ADDR_W-1:0] d);
    int t;
    t = 0;
    in_data  = d;
    in_valid = 1'b1;
    while (!in_ready && t < 40) begin
      @(posedge clk); #1; t++;
    end
    if (t >= 40) chk("accept_timeout", t, 0);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_out(input string tag, input logic [NEURONS*OUT_BW-1:0] exp, input int lat);
    int cnt;
    int busy_bad;
    cnt = 0;
    busy_bad = 0;
    while (!out_valid && cnt < 40) begin
      if (in_ready || cfg_ready) busy_bad++;
      @(posedge clk); #1; cnt++;
    end
    chk({tag, "_lat"}, cnt, lat);
    chk({tag, "_busy"}, busy_bad, 0);
    chk({tag, "_data"}, out_data, exp);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({tag, "_vld_clr"}, out_valid, 0);
    chk({tag, "_rdy_back"}, in_ready, 1);
    chk({tag, "_held"}, out_data, exp);
  endtask

  initial begin
    #12;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_cfg_ready", cfg_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_cfg_drop", cfg_drop, 0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    for (int nrn = 0; nrn < NEURONS; nrn++) begin
      for (int a = 0; a < 256; a++) begin
        cfg_we     = 1'b1;
        cfg_neuron = NIDX_W'(nrn);
        cfg_addr   = 8'(a);
        if (nrn == 2) cfg_data = (a == 8'hCE || a == 8'hCF) ? 2'b01 : 2'b00;
        else          cfg_data = 2'b11;
        @(posedge clk); #1;
      end
    end
    cfg_we = 1'b0;
    chk("prog_no_drop", cfg_drop, 0);

    start(mkvec(8'hCE));
    chk("run_in_ready", in_ready, 0);
    chk("run_cfg_ready", cfg_ready, 0);
    wait_out("ce", expout(2'b01), 17);

    start(mkvec(8'hCD));
    wait_out("cd", expout(2'b00), 17);

    // Backpressure with a second vector waiting
    start(mkvec(8'hCF));
    begin
      int cnt;
      cnt = 0;
      while (!out_valid && cnt < 40) begin
        @(posedge clk); #1; cnt++;
      end
      chk("bp_lat", cnt, 17);
    end
    in_data  = mkvec(8'hCD);
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("bp_data", out_data, expout(2'b01));
      chk("bp_no_accept", in_ready, 0);
      chk("bp_vld", out_valid, 1);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("bp_idle_after_hs", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("bp_second_accept", in_ready, 0);
    wait_out("bp2", expout(2'b00), 17);

    // Config write while busy is rejected
    start(mkvec(8'hCE));
    cfg_we = 1'b1; cfg_neuron = 4'd2; cfg_addr = 8'hCE; cfg_data = 2'b10;
    @(posedge clk); #1;
    cfg_we = 1'b0;
    chk("drop_pulse", cfg_drop, 1);
    @(posedge clk); #1;
    chk("drop_clear", cfg_drop, 0);
    wait_out("busy_wr", expout(2'b01), 15);

    // Write on the accept edge is visible to that vector
    cfg_we = 1'b1; cfg_neuron = 4'd2; cfg_addr = 8'hCE; cfg_data = 2'b10;
    start(mkvec(8'hCE));
    cfg_we = 1'b0;
    chk("same_edge_no_drop", cfg_drop, 0);
    wait_out("same_edge", expout(2'b10), 17);

    // Asynchronous reset mid-run at n=7
    start(mkvec(8'hCD));
    repeat (7) @(posedge clk);
    #3;
    chk("pre_rst_partial", (out_data != 0), 1);
    rst_n = 1'b0;
    #1;
    chk("arst_out_valid", out_valid, 0);
    chk("arst_out_data", out_data, 0);
    chk("arst_in_ready", in_ready, 1);
    chk("arst_cfg_ready", cfg_ready, 1);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    start(mkvec(8'hCE));
    wait_out("post_rst", expout(2'b10), 17);
    start(mkvec(8'hCD));
    wait_out("post_rst_cd", expout(2'b00), 17);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
